// File: rtl/hs_tx_sender.sv
// Source-side handshake transmitter: FIFO-buffered words go out one at a time on sready/din and are held until sidle acks.
// First sready one edge after a word lands in an empty FIFO; in_ready drops when the FIFO is full; an in-flight word is never dropped.

module hs_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdat_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end
endmodule

module hs_tx_sender #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sready,
    output logic [WIDTH-1:0] din,
    input  logic             sidle,
    output logic [CW-1:0]    fifo_count,
    output logic [15:0]      sent_cnt,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t           state_q, state_d;
    logic             sready_q, sready_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [15:0]      wait_q, wait_d;
    logic [15:0]      sent_q, sent_d;
    logic             err_q, err_d;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_dat;

    hs_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdat_i  (in_data),
        .pop_i   (fifo_pop),
        .rdat_o  (head_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready    = !fifo_full;
    assign sready      = sready_q;
    assign din         = din_q;
    assign sent_cnt    = sent_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d  = state_q;
        sready_d = sready_q;
        din_d    = din_q;
        wait_d   = wait_q;
        sent_d   = sent_q;
        err_d    = err_q && !err_clr;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                // sidle still high means the previous four-phase cycle has not closed.
                if (!fifo_empty && !sidle) begin
                    din_d    = head_dat;
                    sready_d = 1'b1;
                    fifo_pop = 1'b1;
                    wait_d   = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (sidle) begin
                    sready_d = 1'b0;
                    state_d  = REL;
                end else if (wait_q != TMO) begin
                    wait_d = wait_q + 16'd1;
                    if (wait_q + 16'd1 == TMO) begin
                        err_d = 1'b1;
                    end
                end
            end
            REL: begin
                if (!sidle) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                sready_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sready_q <= 1'b0;
            din_q    <= '0;
            wait_q   <= '0;
            sent_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sready_q <= sready_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_hs_tx_sender.sv
// Directed bench for hs_tx_sender (WIDTH=32, DEPTH=4, TIMEOUT=10); inputs driven and outputs sampled on the falling edge.

module tb_hs_tx_sender;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        sready;
    logic [31:0] din;
    logic        sidle;
    logic [2:0]  fifo_count;
    logic [15:0] sent_cnt;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_sent = 16'd0;

    hs_tx_sender #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sready      (sready),
        .din         (din),
        .sidle       (sidle),
        .fifo_count  (fifo_count),
        .sent_cnt    (sent_cnt),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Acts as the synchronizer: waits for a request, acks after dly cycles, then releases.
    task automatic xfer(input logic [31:0] exp_w, input int dly);
        int k;
        k = 0;
        while (sready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("xfer_req", {31'd0, sready}, 32'd1);
        check_eq("xfer_din", din, exp_w);
        repeat (dly) @(negedge clk);
        check_eq("xfer_hold", din, exp_w);
        sidle = 1'b1;
        @(negedge clk);
        check_eq("xfer_drop", {31'd0, sready}, 32'd0);
        sidle = 1'b0;
        @(negedge clk);
        exp_sent++;
        check_eq("xfer_cnt", {16'd0, sent_cnt}, {16'd0, exp_sent});
        check_eq("xfer_idle_gap", {31'd0, sready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        sidle    = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_sready", {31'd0, sready}, 32'd0);
        check_eq("rst_din", din, 32'd0);
        check_eq("rst_count", {29'd0, fifo_count}, 32'd0);
        check_eq("rst_sent", {16'd0, sent_cnt}, 32'd0);
        check_eq("rst_err", {31'd0, timeout_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word with a 3-cycle ack delay.
        push_word(32'hDEADBEEF);
        check_eq("t1_count1", {29'd0, fifo_count}, 32'd1);
        check_eq("t1_no_req_yet", {31'd0, sready}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("t1_sready", {31'd0, sready}, 32'd1);
        check_eq("t1_din", din, 32'hDEADBEEF);
        check_eq("t1_count0", {29'd0, fifo_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t1_req_hold", {sready, din[30:0]}, {1'b1, 31'h5EADBEEF});
        end
        sidle = 1'b1;
        @(negedge clk);
        check_eq("t1_sready_fall", {31'd0, sready}, 32'd0);
        check_eq("t1_din_rel", din, 32'hDEADBEEF);
        @(negedge clk);
        sidle = 1'b0;
        @(negedge clk);
        exp_sent = 16'd1;
        check_eq("t1_sent", {16'd0, sent_cnt}, 32'd1);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

        // Fill: five words accepted (one in flight), sixth ignored.
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(i);
            if (i == 6) check_eq("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("t2_count_full", {29'd0, fifo_count}, 32'd4);
        check_eq("t2_inflight", din, 32'hA1);
        for (int i = 1; i <= 5; i++) xfer(32'hA0 + 32'(i), i % 3);
        repeat (3) @(negedge clk);
        check_eq("t2_no_sixth", {31'd0, sready}, 32'd0);
        check_eq("t2_count_empty", {29'd0, fifo_count}, 32'd0);

        // sidle glitch while idle, then sidle held high blocks a new request.
        sidle = 1'b1;
        @(negedge clk);
        sidle = 1'b0;
        @(negedge clk);
        check_eq("glitch_sent", {16'd0, sent_cnt}, {16'd0, exp_sent});
        check_eq("glitch_busy", {31'd0, busy}, 32'd0);
        sidle = 1'b1;
        push_word(32'h55);
        repeat (3) @(negedge clk);
        check_eq("blocked_sready", {31'd0, sready}, 32'd0);
        check_eq("blocked_count", {29'd0, fifo_count}, 32'd1);
        sidle = 1'b0;
        xfer(32'h55, 1);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Ordered stream with a random-delay responder.
        fork
            begin
                for (int w = 1; w <= 8; w++) begin
                    in_valid = 1'b1;
                    in_data  = 32'(w);
                    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 1; i <= 8; i++) xfer(32'(i), int'($urandom_range(0, 3)));
            end
        join
        @(negedge clk);
        check_eq("t3_sent", {16'd0, sent_cnt}, 32'd15);
        check_eq("t3_busy", {31'd0, busy}, 32'd0);

        // Timeout after exactly 10 REQ cycles; set beats a simultaneous clear.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t4_err_clean", {31'd0, timeout_err}, 32'd0);
        push_word(32'h7E57);
        @(negedge clk);
        check_eq("t4_sready", {31'd0, sready}, 32'd1);
        repeat (9) @(negedge clk);
        check_eq("t4_err_before", {31'd0, timeout_err}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t4_err_set_wins", {31'd0, timeout_err}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
        check_eq("t4_still_req", {sready, din[30:0]}, {1'b1, 31'h7E57});
        xfer(32'h7E57, 0);
        check_eq("t4_err_after_xfer", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t4_err_cleared", {31'd0, timeout_err}, 32'd0);

        // Reset while a word is in flight with two buffered.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("t5_pre_sready", {31'd0, sready}, 32'd1);
        check_eq("t5_pre_count", {29'd0, fifo_count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_sready_async", {31'd0, sready}, 32'd0);
        check_eq("t5_count_async", {29'd0, fifo_count}, 32'd0);
        check_eq("t5_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_sent = 16'd0;
        repeat (5) @(negedge clk);
        check_eq("t5_no_spurious", {31'd0, sready}, 32'd0);
        check_eq("t5_sent_zero", {16'd0, sent_cnt}, 32'd0);

        // Completion counter wraps from 0xFFFF to 0.
        force dut.sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_q;
        @(negedge clk);
        check_eq("t6_preload", {16'd0, sent_cnt}, 32'hFFFF);
        exp_sent = 16'hFFFF;
        push_word(32'h66);
        xfer(32'h66, 0);
        check_eq("t6_wrapped", {16'd0, sent_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
